pmem_responder: RTL and testbench
=================================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10, cycles from request acceptance to pmem_resp; legal range 2..255, elaboration error otherwise.
REQ-002 SHALL have parameter INDEX_BITS, default 4, line-store depth 2**INDEX_BITS lines of 256 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pmem_address, input, 32, line address; bits [4:0] ignored.
REQ-006 SHALL have port pmem_read, input, 1, read-line request, held by initiator until pmem_resp.
REQ-007 SHALL have port pmem_write, input, 1, write-line request, held by initiator until pmem_resp.
REQ-008 SHALL have port pmem_wdata, input, 256, write line data.
REQ-009 SHALL have port pmem_rdata, output, 256, registered read line data.
REQ-010 SHALL have port pmem_resp, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port proto_err, output, 1, sticky protocol-violation flag.
REQ-012 SHALL have ports read_count and write_count, output, 16 each, completed-transaction counters.

Function
REQ-013 SHALL implement states IDLE, BUSY, RESP.
REQ-014 IDLE: pmem_read or pmem_write high SHALL latch operation, index = pmem_address[5+INDEX_BITS-1:5], pmem_wdata; load counter with LATENCY-2; go BUSY.
REQ-015 BUSY: counter SHALL decrement each cycle; at zero go RESP.
REQ-016 RESP: pmem_resp SHALL be 1 for exactly one cycle, then IDLE unconditionally.
REQ-017 Request first high in IDLE cycle N SHALL produce pmem_resp in cycle N+LATENCY.
REQ-018 Read: pmem_rdata SHALL equal the stored line at latched index during the RESP cycle and hold until the next read RESP.
REQ-019 Write: stored line SHALL be updated with latched wdata at the end of the RESP cycle; pmem_rdata unchanged.
REQ-020 Request still high during RESP SHALL NOT start a new transaction; a request present in the IDLE cycle after RESP SHALL be accepted (back-to-back write-back then allocate).
REQ-021 Request dropped or changed during BUSY SHALL be ignored; latched transaction completes.
REQ-022 pmem_read and pmem_write both high at acceptance SHALL service the write and set proto_err.
REQ-023 Address index aliases modulo 2**INDEX_BITS; upper bits ignored.
REQ-024 pmem_resp SHALL be 0 in IDLE and BUSY.

Reset
REQ-025 rst low SHALL immediately force IDLE, pmem_resp 0, pmem_rdata 0, proto_err 0, counters 0, latched fields 0.
REQ-026 Reset mid-BUSY SHALL abandon the transaction without a line-store write; line-store contents not reset.

Configuration
REQ-027 Macro PMEM_RESPONDER_STATS_EN defined: read_count/write_count SHALL increment by 1 at each read/write RESP cycle, saturating at 16'hFFFF.
REQ-028 Macro undefined: read_count and write_count SHALL be constant 0 and counter logic absent.

Structure
REQ-029 Package pmem_pkg SHALL hold state enum, LINE_WIDTH=256, OFFSET_BITS=5, counter width constant.
REQ-030 Line storage SHALL be sub-module pmem_line_array (one write port, one read port, synchronous write, no reset).

Verification
REQ-031 Write 0x...A5 line to address 0x0000_0040, then read 0x0000_0040 -> each pmem_resp exactly 10 cycles after request, rdata = written line.
REQ-032 Write 0x20 held until resp, pmem_read to 0x40 raised the cycle after -> read accepted that cycle, resp 10 cycles later, no extra resp.
REQ-033 pmem_read and pmem_write both high to 0x60 -> write performed, proto_err=1 and stays 1 until reset.
REQ-034 rst low during BUSY of a write to 0x80 -> no resp, subsequent read of 0x80 returns prior contents.
REQ-035 Write to 0x0 then 0x200 (INDEX_BITS=4) -> read 0x0 returns second line (alias).
REQ-036 With PMEM_RESPONDER_STATS_EN, 3 reads and 2 writes -> read_count=3, write_count=2; without macro both 0.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared constants, FSM state type and the saturating-increment helper for the
// pmem_responder line-memory model.
package pmem_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_WIDTH   = 8;
    localparam int STAT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } pmem_state_e;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == {STAT_WIDTH{1'b1}}) ? v : v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line store: one synchronous write port, one combinational read port, no reset.
module pmem_line_array
    import pmem_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] waddr,
    input  logic [LINE_WIDTH-1:0] wdata,
    input  logic [INDEX_BITS-1:0] raddr,
    output logic [LINE_WIDTH-1:0] rdata
);

    logic [LINE_WIDTH-1:0] mem_q [2**INDEX_BITS];

    // Line write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency cache-line memory responder (IDLE -> BUSY -> RESP).
// Optional transaction statistics enabled by macro PMEM_RESPONDER_STATS_EN.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY    = 10,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pmem_address,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  proto_err,
    output logic [STAT_WIDTH-1:0] read_count,
    output logic [STAT_WIDTH-1:0] write_count
);

    if (LATENCY < 2 || LATENCY > 255) begin : g_bad_latency
        $error("pmem_responder: LATENCY must be within 2..255");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 2);

    pmem_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  err_q, err_d;
    logic [LINE_WIDTH-1:0] line_rd_s;
    logic                  line_we_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^{pmem_address[31:OFFSET_BITS+INDEX_BITS],
                             pmem_address[OFFSET_BITS-1:0]};

    // The store is written only in RESP, so a reset during BUSY never commits.
    assign line_we_s = (state_q == ST_RESP) && wr_q;

    pmem_line_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_lines (
        .clk  (clk),
        .we   (line_we_s),
        .waddr(idx_q),
        .wdata(wdata_q),
        .raddr(idx_q),
        .rdata(line_rd_s)
    );

    // Next-state and output-register logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                    wr_d    = pmem_write;
                    idx_d   = pmem_address[OFFSET_BITS +: INDEX_BITS];
                    wdata_d = pmem_wdata;
                    if (pmem_read && pmem_write) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == {CNT_WIDTH{1'b0}}) begin
                    state_d = ST_RESP;
                    resp_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = line_rd_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and latched-transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_WIDTH{1'b0}};
            wr_q    <= 1'b0;
            idx_q   <= {INDEX_BITS{1'b0}};
            wdata_q <= {LINE_WIDTH{1'b0}};
            rdata_q <= {LINE_WIDTH{1'b0}};
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = resp_q;
    assign proto_err  = err_q;

`ifdef PMEM_RESPONDER_STATS_EN
    logic [STAT_WIDTH-1:0] rd_cnt_q, wr_cnt_q;

    // Completed-transaction counters, bumped at the end of each RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= {STAT_WIDTH{1'b0}};
            wr_cnt_q <= {STAT_WIDTH{1'b0}};
        end else if (state_q == ST_RESP) begin
            if (wr_q) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end else begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
        end else begin
            rd_cnt_q <= rd_cnt_q;
            wr_cnt_q <= wr_cnt_q;
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`else
    assign read_count  = {STAT_WIDTH{1'b0}};
    assign write_count = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: transaction-level model plus
// directed scenarios with hand-computed latencies and line values.
module tb_pmem_responder;

    localparam int LAT = 10;
    localparam int IB  = 4;
`ifdef PMEM_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  pmem_address = 32'h0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;
    logic [15:0]  read_count;
    logic [15:0]  write_count;

    int n_vec  = 0;
    int n_fail = 0;

    pmem_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clk         (clk),
        .rst         (rst),
        .pmem_address(pmem_address),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .proto_err   (proto_err),
        .read_count  (read_count),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one transaction occupies cycles N..N+LAT.
    logic [255:0] mdl_mem [2**IB];
    logic         exp_resp  = 1'b0;
    logic [255:0] exp_rdata = '0;
    logic         exp_err   = 1'b0;
    logic [15:0]  exp_rc    = 16'd0;
    logic [15:0]  exp_wc    = 16'd0;

    initial begin : model
        int cyc = 0;
        int busy_until = -1000;
        int resp_cyc = -1;
        bit pend = 1'b0;
        bit m_wr = 1'b0;
        int m_idx = 0;
        logic [255:0] m_data = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pend = 1'b0; busy_until = -1000;
                exp_resp = 1'b0; exp_rdata = '0; exp_err = 1'b0;
                exp_rc = 16'd0; exp_wc = 16'd0;
            end else begin
                if (pend && cyc == resp_cyc) begin
                    if (m_wr) begin
                        mdl_mem[m_idx] = m_data;
                        if (STATS && exp_wc != 16'hFFFF) exp_wc = exp_wc + 16'd1;
                    end else begin
                        if (STATS && exp_rc != 16'hFFFF) exp_rc = exp_rc + 16'd1;
                    end
                    pend = 1'b0;
                end
                if (cyc > busy_until && (pmem_read || pmem_write)) begin
                    pend = 1'b1;
                    resp_cyc = cyc + LAT;
                    busy_until = resp_cyc;
                    m_wr = pmem_write;
                    m_idx = int'(pmem_address[5 +: IB]);
                    m_data = pmem_wdata;
                    if (pmem_read && pmem_write) exp_err = 1'b1;
                end
                cyc++;
                exp_resp = pend && (cyc == resp_cyc);
                if (exp_resp && !m_wr) exp_rdata = mdl_mem[m_idx];
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("pmem_resp", {255'd0, pmem_resp}, {255'd0, exp_resp});
            chk("pmem_rdata", pmem_rdata, exp_rdata);
            chk("proto_err", {255'd0, proto_err}, {255'd0, exp_err});
            chk("read_count", {240'd0, read_count}, {240'd0, exp_rc});
            chk("write_count", {240'd0, write_count}, {240'd0, exp_wc});
        end
    end

    // Drive a request and hold it until pmem_resp; returns observed latency.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] data, input bit mess, output int lat);
        @(posedge clk); #1;
        pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = data;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                lat = k;
                break;
            end
            if (mess && k == 3) begin
                pmem_read = 1'b1; pmem_write = 1'b0;
                pmem_address = 32'h0000_01E0; pmem_wdata = '0;
            end
        end
        if (lat < 0) begin
            n_vec++; n_fail++;
            $display("FAIL txn_timeout: got no pmem_resp within 300 cycles, required one");
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        pmem_read = 1'b0; pmem_write = 1'b0;
    endtask

    initial begin : stim
        int lat;
        logic [255:0] line_a, line_b, line_c, line_d, line_e, line_f, line_g;
        line_a = {32{8'hA5}};
        line_b = {8{32'hB0B0_0080}};
        line_c = {8{32'hC0C0_0080}};
        line_d = {8{32'hD00D_0020}};
        line_e = {8{32'hE00E_0060}};
        line_f = {8{32'hF00F_0000}};
        line_g = {8{32'h6006_0200}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", pmem_rdata, 256'd0);
        chk("reset_resp", {255'd0, pmem_resp}, 256'd0);
        @(posedge clk); #1; rst = 1'b1;

        txn(1'b0, 1'b1, 32'h0000_0040, line_a, 1'b0, lat); idle();
        chk("wr40_latency", lat, 256'd10);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, lat);
        chk("rd40_latency", lat, 256'd10);
        chk("rd40_data", pmem_rdata, line_a);
        idle();

        txn(1'b0, 1'b1, 32'h0000_0020, line_d, 1'b0, lat);
        chk("wr20_latency", lat, 256'd10);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, lat);
        chk("b2b_rd40_latency", lat, 256'd10);
        chk("b2b_rd40_data", pmem_rdata, line_a);
        idle();
        repeat (15) @(posedge clk);

        txn(1'b1, 1'b1, 32'h0000_0060, line_e, 1'b0, lat); idle();
        chk("both60_latency", lat, 256'd10);
        chk("both60_rdata_unchanged", pmem_rdata, line_a);
        repeat (3) @(negedge clk);
        chk("proto_err_set", {255'd0, proto_err}, 256'd1);

        txn(1'b0, 1'b1, 32'h0000_0080, line_b, 1'b0, lat); idle();
        chk("proto_err_sticky", {255'd0, proto_err}, 256'd1);

        @(posedge clk); #1;
        pmem_write = 1'b1; pmem_address = 32'h0000_0080; pmem_wdata = line_c;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_resp", {255'd0, pmem_resp}, 256'd0);
        end
        @(posedge clk); #1; rst = 1'b0; pmem_write = 1'b0;
        @(negedge clk);
        chk("rst_proto_err", {255'd0, proto_err}, 256'd0);
        chk("rst_rdata", pmem_rdata, 256'd0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_abort_no_resp", {255'd0, pmem_resp}, 256'd0);
        end

        txn(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, lat); idle();
        chk("rd80_prior_data", pmem_rdata, line_b);

        txn(1'b0, 1'b1, 32'h0000_0000, line_f, 1'b0, lat); idle();
        txn(1'b0, 1'b1, 32'h0000_0200, line_g, 1'b1, lat); idle();
        chk("wr200_changed_req_latency", lat, 256'd10);
        txn(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, lat); idle();
        chk("rd0_alias_data", pmem_rdata, line_g);
        txn(1'b1, 1'b0, 32'h0000_0060, '0, 1'b0, lat); idle();
        chk("rd60_both_wrote", pmem_rdata, line_e);

        repeat (3) @(negedge clk);
        chk("read_count_final", {240'd0, read_count}, STATS ? 256'd3 : 256'd0);
        chk("write_count_final", {240'd0, write_count}, STATS ? 256'd2 : 256'd0);

        repeat (15) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
